// File: rtl/cpu_pkg.sv
// Shared definitions for the serial execution controller.
//   state_t        : 3-bit FSM state encoding
//   OPC_NOP        : opcode that skips the bit-serial execution phase
//   DEFAULT_DATA_W : default bit-serial operand width (EXEC cycles)
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_HI = 3'd1,
        ST_LOAD    = 3'd2,
        ST_EXEC    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [3:0] OPC_NOP        = 4'h0;
    localparam int         DEFAULT_DATA_W = 8;

endpackage

// File: rtl/btn_sync_edge.sv
// Push-button synchroniser and rising-edge detector.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   btn      : raw button, asynchronous to clk, active-high
//   btn_edge : one-cycle pulse per press, however long the button is held
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_edge
);

    logic sync0;
    logic sync1;
    logic prev;
    logic started;
    logic armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0   <= 1'b0;
            sync1   <= 1'b0;
            prev    <= 1'b0;
            started <= 1'b0;
            armed   <= 1'b0;
        end else begin
            sync0   <= btn;
            sync1   <= sync0;
            prev    <= sync1;
            started <= 1'b1;
            // The sync chain leaves reset at 0, so a button already held
            // would look like a fresh rise. Only arm once the button has
            // really been seen released after reset.
            if (started && !sync0)
                armed <= 1'b1;
        end
    end

    assign btn_edge = armed & sync1 & ~prev;

endmodule

// File: rtl/serial_exec_ctrl.sv
// Two-press instruction loader and bit-serial execution sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw load button
//   dip        : instruction byte from DIP switches
//   opcode     : latched opcode (first press, dip[3:0])
//   operand    : latched 12-bit field (first press dip[7:4], second press dip)
//   le         : one-cycle parallel-load enable
//   ae         : accumulate enable, high for DATA_W cycles
//   bit_idx    : serial bit position during EXEC, LSB first
//   busy       : high in LOAD, EXEC and DONE
//   done       : one-cycle completion pulse
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | wait for first press, latch opcode and operand[3:0]
// WAIT_HI | wait for second press, latch operand[11:4]
// LOAD    | le pulse; NOP skips straight to DONE
// EXEC    | ae high, bit_idx steps 0..DATA_W-1
// DONE    | done pulse, return to IDLE
module serial_exec_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn,
    input  logic [7:0]       dip,
    output logic [3:0]       opcode,
    output logic [11:0]      operand,
    output logic             le,
    output logic             ae,
    output logic [CNT_W-1:0] bit_idx,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] IDX_ONE  = CNT_W'(1);

    logic   btn_edge;
    state_t state;

    btn_sync_edge u_btn_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .btn_edge (btn_edge)
    );

    // Outputs are set on entry to the state that owns them so that le, ae
    // and done come straight from flops and never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            opcode  <= '0;
            operand <= '0;
            le      <= 1'b0;
            ae      <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            bit_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (btn_edge) begin
                        opcode       <= dip[3:0];
                        operand[3:0] <= dip[7:4];
                        state        <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (btn_edge) begin
                        operand[11:4] <= dip;
                        le            <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    le      <= 1'b0;
                    bit_idx <= '0;
                    if (opcode == OPC_NOP) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        ae    <= 1'b1;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (bit_idx == LAST_IDX) begin
                        ae      <= 1'b0;
                        done    <= 1'b1;
                        bit_idx <= '0;
                        state   <= ST_DONE;
                    end else begin
                        bit_idx <= bit_idx + IDX_ONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    le      <= 1'b0;
                    ae      <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    bit_idx <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_exec_ctrl.sv
module tb_serial_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn;
    logic [7:0]  dip;

    logic [3:0]  opc8,  opc16;
    logic [11:0] opd8,  opd16;
    logic        le8,   le16;
    logic        ae8,   ae16;
    logic [3:0]  idx8;
    logic [4:0]  idx16;
    logic        busy8, busy16;
    logic        done8, done16;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what the latches should hold after the last capture.
    logic [3:0]  m_opc;
    logic [11:0] m_opd;

    always #5 clk = ~clk;

    serial_exec_ctrl #(.DATA_W(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .btn(btn), .dip(dip),
        .opcode(opc8), .operand(opd8), .le(le8), .ae(ae8),
        .bit_idx(idx8), .busy(busy8), .done(done8)
    );

    serial_exec_ctrl #(.DATA_W(16), .CNT_W(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .btn(btn), .dip(dip),
        .opcode(opc16), .operand(opd16), .le(le16), .ae(ae16),
        .bit_idx(idx16), .busy(busy16), .done(done16)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk_eq({tag, "_le8"},    32'(le8),    32'd0);
        chk_eq({tag, "_ae8"},    32'(ae8),    32'd0);
        chk_eq({tag, "_done8"},  32'(done8),  32'd0);
        chk_eq({tag, "_busy8"},  32'(busy8),  32'd0);
        chk_eq({tag, "_idx8"},   32'(idx8),   32'd0);
        chk_eq({tag, "_opc8"},   32'(opc8),   32'(m_opc));
        chk_eq({tag, "_opd8"},   32'(opd8),   32'(m_opd));
        chk_eq({tag, "_le16"},   32'(le16),   32'd0);
        chk_eq({tag, "_ae16"},   32'(ae16),   32'd0);
        chk_eq({tag, "_done16"}, 32'(done16), 32'd0);
        chk_eq({tag, "_busy16"}, 32'(busy16), 32'd0);
        chk_eq({tag, "_idx16"},  32'(idx16),  32'd0);
        chk_eq({tag, "_opc16"},  32'(opc16),  32'(m_opc));
        chk_eq({tag, "_opd16"},  32'(opd16),  32'(m_opd));
    endtask

    // Expected behaviour c negedges after the second press is raised:
    // capture on the 3rd edge, so le shows at c=3; then w EXEC cycles
    // (none for NOP) and a done pulse.
    task automatic check_cycle(input string nm, input int w, input int c, input bit nop,
                               input logic le, input logic ae, input logic done,
                               input logic busy, input logic [4:0] idx,
                               input logic [3:0] opc, input logic [11:0] opd);
        int  last;
        bit  le_e, ae_e, done_e, busy_e;
        int  idx_e;
        last   = nop ? 4 : 4 + w;
        le_e   = (c == 3);
        ae_e   = !nop && (c >= 4) && (c <= 3 + w);
        done_e = (c == last);
        busy_e = (c >= 3) && (c <= last);
        idx_e  = ae_e ? c - 4 : 0;
        chk_eq($sformatf("%s_le_c%0d", nm, c),   32'(le),   32'(le_e));
        chk_eq($sformatf("%s_ae_c%0d", nm, c),   32'(ae),   32'(ae_e));
        chk_eq($sformatf("%s_done_c%0d", nm, c), 32'(done), 32'(done_e));
        chk_eq($sformatf("%s_busy_c%0d", nm, c), 32'(busy), 32'(busy_e));
        chk_eq($sformatf("%s_idx_c%0d", nm, c),  32'(idx),  32'(idx_e));
        if (c >= 3) begin
            chk_eq($sformatf("%s_opc_c%0d", nm, c), 32'(opc), 32'(m_opc));
            chk_eq($sformatf("%s_opd_c%0d", nm, c), 32'(opd), 32'(m_opd));
        end
    endtask

    task automatic first_press(input logic [7:0] d, input int hold);
        @(negedge clk);
        dip = d;
        btn = 1'b1;
        repeat (hold) @(negedge clk);
        btn = 1'b0;
        repeat (4) @(negedge clk);
        m_opc      = d[3:0];
        m_opd[3:0] = d[7:4];
        check_idle("first");
    endtask

    // noisy adds three short presses that land while the FSM is busy.
    task automatic second_press_trace(input logic [7:0] d, input int hold,
                                      input bit noisy, input int stop_c);
        bit nop;
        nop = (m_opc == 4'h0);
        @(negedge clk);
        dip = d;
        btn = 1'b1;
        m_opd[11:4] = d;
        for (int c = 1; c <= stop_c; c++) begin
            @(negedge clk);
            check_cycle("w8",  8,  c, nop, le8,  ae8,  done8,  busy8,  {1'b0, idx8}, opc8,  opd8);
            check_cycle("w16", 16, c, nop, le16, ae16, done16, busy16, idx16,        opc16, opd16);
            if (c < hold)
                btn = 1'b1;
            else if (noisy && (c == 4 || c == 6 || c == 8))
                btn = 1'b1;
            else
                btn = 1'b0;
        end
    endtask

    task automatic run_op(input logic [7:0] d1, input logic [7:0] d2,
                          input int h1, input int h2, input bit noisy);
        first_press(d1, h1);
        second_press_trace(d2, h2, noisy, 24);
        check_idle("after_op");
    endtask

    initial begin
        logic [7:0] d1, d2, dn;
        rst_n = 1'b0;
        btn   = 1'b0;
        dip   = 8'h00;
        m_opc = 4'h0;
        m_opd = 12'h000;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_idle("post_reset");

        // Directed two-press instruction.
        run_op(8'hA3, 8'h5C, 3, 3, 1'b0);
        chk_eq("dir_opcode",  32'(opc8), 32'h3);
        chk_eq("dir_operand", 32'(opd8), 32'h5CA);

        // Long hold: one capture only, then the FSM waits for the high byte.
        d1 = 8'h7B;
        @(negedge clk);
        dip = d1;
        btn = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            chk_eq($sformatf("hold_le8_c%0d", c),   32'(le8),   32'd0);
            chk_eq($sformatf("hold_busy16_c%0d", c), 32'(busy16), 32'd0);
            if (c == 10) dip = 8'hE4;
        end
        btn = 1'b0;
        repeat (4) @(negedge clk);
        m_opc      = d1[3:0];
        m_opd[3:0] = d1[7:4];
        check_idle("hold");
        second_press_trace(8'h96, 3, 1'b0, 24);
        check_idle("hold_after");

        // NOP: le then done, no EXEC.
        run_op(8'h10, 8'h3D, 4, 3, 1'b0);

        // Presses during EXEC are dropped; the FSM ends in IDLE.
        run_op(8'hC5, 8'h21, 3, 3, 1'b1);
        dn = 8'h4E;
        first_press(dn, 3);
        second_press_trace(8'hB7, 3, 1'b0, 24);
        check_idle("noisy_after");

        // Reset mid-EXEC at bit_idx 4.
        first_press(8'h69, 3);
        second_press_trace(8'hF0, 3, 1'b0, 8);
        chk_eq("abort_idx8_pre", 32'(idx8), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        m_opc = 4'h0;
        m_opd = 12'h000;
        check_idle("abort_async");
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            chk_eq($sformatf("abort_done8_c%0d", c),  32'(done8),  32'd0);
            chk_eq($sformatf("abort_done16_c%0d", c), 32'(done16), 32'd0);
        end
        check_idle("abort_idle");
        run_op(8'h58, 8'h1A, 3, 3, 1'b0);

        // Button held through reset release yields no capture.
        @(negedge clk);
        dip = 8'hA7;
        btn = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        m_opc = 4'h0;
        m_opd = 12'h000;
        repeat (12) @(negedge clk);
        check_idle("held_reset");
        btn = 1'b0;
        repeat (4) @(negedge clk);
        check_idle("held_reset_rel");

        // Randomized instructions.
        for (int i = 0; i < 6; i++) begin
            d1 = 8'($urandom);
            if (i == 2) d1[3:0] = 4'h0;
            d2 = 8'($urandom);
            run_op(d1, d2, $urandom_range(3, 8), $urandom_range(3, 6), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
